mips_inst_feeder: RTL

Instruction-side responder for the single-cycle MIPS core. Accepts 32-bit instructions from an external host over a valid/ready handshake, buffers them in a FIFO, and issues one instruction per clock on `extInst`. It watches the core's `pc_current`/`pc_next`. On a control-flow discontinuity it flushes the buffer and tells the host where to resume. It is the consumer end of the `extInst` path that the verification driver feeds.

---
 rtl/mips_inst_feeder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mips_inst_feeder.sv
// mips_inst_feeder: instruction-side responder for the single-cycle MIPS core.
// Buffers host instructions in a FIFO and issues one per clock on extInst.
// Optional feature macro: MIPS_FEEDER_REDIRECT_EN enables discontinuity
// detection with flush and redirect to the host. When it is undefined,
// redirect and redirect_pc are tied low.
module mips_inst_feeder #(
    parameter int unsigned DEPTH = 8,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [31:0]                in_inst,
    output logic                       in_ready,
    input  logic                       hold,
    output logic [31:0]                extInst,
    output logic                       inst_valid,
    input  logic [31:0]                pc_current,
    input  logic [31:0]                pc_next,
    output logic                       redirect,
    output logic [31:0]                redirect_pc,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = $clog2(DEPTH + 1);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    logic [31:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_count;
    logic [31:0]   r_ext_inst;
    logic          r_inst_valid;

    logic          w_disc;
    logic          w_in_flush;
    logic          w_push;
    logic          w_issue;
    logic          w_pop;
    logic          w_nonempty;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = !rst && (r_count < LW'(DEPTH));

    // A push landing on the discontinuity edge belongs to the stale stream.
    assign w_push  = in_valid && in_ready && !w_disc;
    assign w_issue = !w_in_flush && !hold && !w_disc;
    assign w_pop   = w_issue && w_nonempty;

`ifdef MIPS_FEEDER_REDIRECT_EN
    logic [0:0]  r_state;
    logic [31:0] r_redirect_pc;

    // inst_valid is never set while flushing, so the check only fires in RUN.
    assign w_disc = (r_state == S_RUN) && r_inst_valid && !hold &&
                    (pc_next != pc_current + 32'd4);
    assign w_in_flush  = (r_state == S_FLUSH);
    assign redirect    = w_in_flush;
    assign redirect_pc = r_redirect_pc;

    // Two-state flush controller and resume-PC capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_disc) begin
                        r_state       <= S_FLUSH;
                        r_redirect_pc <= pc_next;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end
`else
    logic w_unused_pc;

    assign w_unused_pc = ^{pc_current, pc_next};
    assign w_disc      = 1'b0;
    assign w_in_flush  = 1'b0;
    assign redirect    = 1'b0;
    assign redirect_pc = '0;
`endif

    // FIFO storage write; contents need no reset because the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_inst;
        end
    end

    // Pointers and occupancy; a flush empties the FIFO like reset does.
    always_ff @(posedge clk) begin
        if (rst || w_disc) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue register: head word or NOP filler, frozen by hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ext_inst   <= NOP;
            r_inst_valid <= 1'b0;
        end else if (w_in_flush || w_disc) begin
            r_ext_inst   <= NOP;
            r_inst_valid <= 1'b0;
        end else if (w_issue) begin
            r_ext_inst   <= w_nonempty ? r_mem[r_rd_ptr] : NOP;
            r_inst_valid <= w_nonempty;
        end
    end

    assign extInst    = r_ext_inst;
    assign inst_valid = r_inst_valid;
    assign level      = r_count;

endmodule
